// File: rtl/sort_pkg.sv
// Shared constants and types for the sort serializer.
//   SORT_WIDTH : default element width in bits
//   SORT_DEPTH : default number of elements per sorted vector
//   state_e    : serializer FSM states (IDLE, STREAM)
package sort_pkg;

  localparam int SORT_WIDTH = 32;
  localparam int SORT_DEPTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage : sort_pkg

// File: rtl/sort_serializer.sv
// Sort serializer: captures a full sorted vector from the sorter in one cycle
// and replays it element by element (smallest first) on a valid/ready stream.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   vec_valid  : single-cycle strobe, sorted vector present on vec_data
//   vec_data   : DEPTH x WIDTH sorted vector, element 0 is the smallest
//   vec_ready  : block can capture a vector this cycle
//   m_valid    : m_data holds a valid element
//   m_ready    : downstream accepts the element this cycle
//   m_data     : current element
//   m_index    : position of m_data inside its vector
//   m_last     : m_data is element DEPTH-1
//   overflow   : sticky, a vector arrived while vec_ready was 0 and was dropped
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is 1 it stays 1, with m_data/m_index/m_last frozen, until that
// beat transfers. The vector input has no backpressure: vec_valid is a strobe,
// and a strobe seen while vec_ready is 0 is discarded and flagged in overflow.
module sort_serializer
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int DEPTH = SORT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vec_valid,
  input  logic [DEPTH-1:0][WIDTH-1:0] vec_data,
  output logic                        vec_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic [$clog2(DEPTH)-1:0]    m_index,
  output logic                        m_last,
  output logic                        overflow,
  output state_e                      dbg_state
);

  localparam int IW = $clog2(DEPTH);

  state_e                      r_state;
  state_e                      w_next_state;
  logic [DEPTH-1:0][WIDTH-1:0] r_cap;
  logic [IW-1:0]               r_idx;
  logic [IW-1:0]               w_next_idx;
  logic                        r_overflow;

  logic w_valid;
  logic w_last;
  logic w_xfer;
  logic w_vec_ready;
  logic w_cap;

  assign w_valid = (r_state == STREAM);
  assign w_last  = w_valid && (r_idx == IW'(DEPTH - 1));
  assign w_xfer  = w_valid && m_ready;
  // The only STREAM cycle that can take a new vector is the one retiring the
  // last beat; this is what lets vectors run back-to-back with no bubble.
  assign w_vec_ready = (r_state == IDLE) || (w_xfer && w_last);
  assign w_cap       = vec_valid && w_vec_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    if (w_cap) begin
      w_next_state = STREAM;
      w_next_idx   = '0;
    end else if (w_xfer) begin
      if (w_last) begin
        w_next_state = IDLE;
      end else begin
        w_next_idx = r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // Clearing the capture register on reset makes m_data read 0 while idle
  // after reset, since the index is also 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap <= '0;
    end else if (w_cap) begin
      r_cap <= vec_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (vec_valid && !w_vec_ready) begin
      r_overflow <= 1'b1;
    end
  end

  assign vec_ready = w_vec_ready;
  assign m_valid   = w_valid;
  assign m_data    = r_cap[r_idx];
  assign m_index   = r_idx;
  assign m_last    = w_last;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule : sort_serializer

// File: tb/tb_sort_serializer.sv
// Testbench for sort_serializer: directed vectors with hand-written expected
// beats pushed into a scoreboard queue; a negedge monitor pops and compares
// every transferred beat and checks stability of stalled beats.
module tb_sort_serializer;
  import sort_pkg::*;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int IW = $clog2(D);

  typedef logic [D-1:0][W-1:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           vec_valid = 1'b0;
  vec_t           vec_data  = '0;
  logic           vec_ready;
  logic           m_valid;
  logic           m_ready   = 1'b1;
  logic [W-1:0]   m_data;
  logic [IW-1:0]  m_index;
  logic           m_last;
  logic           overflow;
  state_e         dbg_state;

  sort_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .vec_valid (vec_valid),
    .vec_data  (vec_data),
    .vec_ready (vec_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_idx_q[$];
  logic          exp_last_q[$];

  int total    = 0;
  int bad      = 0;
  int beat_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, where m_valid/m_ready are stable
  // for the upcoming rising edge.
  logic          hold_pend = 1'b0;
  logic [W-1:0]  hold_data;
  logic [IW-1:0] hold_idx;
  logic [W-1:0]  e_data;
  logic [IW-1:0] e_idx;
  logic          e_last;

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(m_valid), 64'(1'b1));
        chk("hold_data",  64'(m_data),  64'(hold_data));
        chk("hold_index", 64'(m_index), 64'(hold_idx));
        hold_pend = 1'b0;
      end
      if (m_valid && !m_ready) begin
        hold_pend = 1'b1;
        hold_data = m_data;
        hold_idx  = m_index;
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h index %0d, expected no beat", m_data, m_index);
        end else begin
          e_data = exp_q.pop_front();
          e_idx  = exp_idx_q.pop_front();
          e_last = exp_last_q.pop_front();
          chk("beat_data",  64'(m_data),  64'(e_data));
          chk("beat_index", 64'(m_index), 64'(e_idx));
          chk("beat_last",  64'(m_last),  64'(e_last));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(v[i]);
      exp_idx_q.push_back(IW'(i));
      exp_last_q.push_back(i == D - 1);
    end
  endtask

  // Strobe a vector for one cycle; only an accepted vector is expected back.
  task automatic send_vec(input vec_t v, input bit accept);
    vec_valid = 1'b1;
    vec_data  = v;
    if (accept) push_vec(v);
    tick(1);
    vec_valid = 1'b0;
    vec_data  = '0;
  endtask

  vec_t va, vb, vd;
  int   bc0;

  initial begin
    va = {32'd25, 32'd18, 32'd10, 32'd7, 32'd5, 32'd3, 32'd2, 32'd1};
    vb = {32'd31, 32'd30, 32'd12, 32'd11, 32'd9, 32'd6, 32'd4, 32'd4};
    vd = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'd0, 32'd0, 32'd0, 32'd0};

    // Reset state
    #2;
    chk("rst_m_valid",  64'(m_valid),  64'(1'b0));
    chk("rst_m_last",   64'(m_last),   64'(1'b0));
    chk("rst_overflow", 64'(overflow), 64'(1'b0));
    chk("rst_m_index",  64'(m_index),  64'(0));
    chk("rst_m_data",   64'(m_data),   64'(0));
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("idle_vec_ready", 64'(vec_ready), 64'(1'b1));
    chk("idle_state",     64'(dbg_state), 64'(IDLE));

    // Basic: 8 beats in 8 consecutive cycles, first one right after capture
    bc0 = beat_cnt;
    send_vec(va, 1'b1);
    chk("basic_first_valid", 64'(m_valid), 64'(1'b1));
    chk("basic_first_data",  64'(m_data),  64'(32'd1));
    chk("basic_busy_ready",  64'(vec_ready), 64'(1'b0));
    tick(8);
    chk("basic_beats",     64'(beat_cnt - bc0), 64'(8));
    chk("basic_end_valid", 64'(m_valid),   64'(1'b0));
    chk("basic_end_state", 64'(dbg_state), 64'(IDLE));
    tick(2);

    // Backpressure: stall 3 cycles at index 2
    bc0 = beat_cnt;
    send_vec(va, 1'b1);
    tick(2);
    m_ready = 1'b0;
    tick(3);
    chk("bp_index", 64'(m_index), 64'(2));
    chk("bp_data",  64'(m_data),  64'(32'd3));
    chk("bp_valid", 64'(m_valid), 64'(1'b1));
    m_ready = 1'b1;
    tick(6);
    chk("bp_beats", 64'(beat_cnt - bc0), 64'(8));
    chk("bp_end_state", 64'(dbg_state), 64'(IDLE));
    tick(2);

    // Back-to-back: second vector strobed on the last-beat cycle
    bc0 = beat_cnt;
    send_vec(va, 1'b1);
    tick(7);
    chk("b2b_last_before", 64'(m_last),    64'(1'b1));
    chk("b2b_vec_ready",   64'(vec_ready), 64'(1'b1));
    send_vec(vb, 1'b1);
    chk("b2b_no_bubble_valid", 64'(m_valid), 64'(1'b1));
    chk("b2b_no_bubble_index", 64'(m_index), 64'(0));
    tick(8);
    chk("b2b_beats",    64'(beat_cnt - bc0), 64'(16));
    chk("b2b_overflow", 64'(overflow), 64'(1'b0));
    chk("b2b_end_state", 64'(dbg_state), 64'(IDLE));
    tick(2);

    // Overflow: second vector strobed at index 3 is dropped
    bc0 = beat_cnt;
    send_vec(va, 1'b1);
    tick(3);
    chk("ovf_index_at_strobe", 64'(m_index),   64'(3));
    chk("ovf_vec_ready",       64'(vec_ready), 64'(1'b0));
    send_vec(vb, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'(1'b1));
    tick(4);
    chk("ovf_beats",     64'(beat_cnt - bc0), 64'(8));
    chk("ovf_end_state", 64'(dbg_state), 64'(IDLE));
    tick(3);
    chk("ovf_sticky", 64'(overflow), 64'(1'b1));

    // Reset at index 5: remaining elements are abandoned
    send_vec(va, 1'b1);
    tick(5);
    chk("rstm_index_before", 64'(m_index), 64'(5));
    rst = 1'b0;
    exp_q.delete();
    exp_idx_q.delete();
    exp_last_q.delete();
    #1;
    chk("rstm_m_valid",  64'(m_valid),  64'(1'b0));
    chk("rstm_overflow", 64'(overflow), 64'(1'b0));
    chk("rstm_m_index",  64'(m_index),  64'(0));
    chk("rstm_m_data",   64'(m_data),   64'(0));
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("rstm_vec_ready", 64'(vec_ready), 64'(1'b1));
    chk("rstm_idle_valid", 64'(m_valid), 64'(1'b0));

    // Duplicates and extremes, also the first vector after reset
    bc0 = beat_cnt;
    send_vec(vd, 1'b1);
    chk("dup_first_index", 64'(m_index), 64'(0));
    tick(8);
    chk("dup_beats",     64'(beat_cnt - bc0), 64'(8));
    chk("dup_end_state", 64'(dbg_state), 64'(IDLE));
    tick(2);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sort_serializer

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one element.
REQ-002 Parameter DEPTH, default 8, elements per vector; power of two, >= 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 vec_valid  input  1  single-cycle strobe: sorted vector present on vec_data.
REQ-006 vec_data  input  DEPTH x WIDTH  sorted vector; element 0 is the smallest.
REQ-007 vec_ready  output  1  block can capture a vector this cycle.
REQ-008 m_valid  output  1  m_data holds a valid element.
REQ-009 m_ready  input  1  downstream accepts the element this cycle.
REQ-010 m_data  output  WIDTH  current element.
REQ-011 m_index  output  $clog2(DEPTH)  position of m_data within its vector.
REQ-012 m_last  output  1  m_data is element DEPTH-1.
REQ-013 overflow  output  1  sticky: a vector was dropped.

Function
REQ-014 States SHALL be IDLE and STREAM, with a single DEPTH x WIDTH capture register and an index counter.
REQ-015 vec_ready SHALL be 1 in IDLE, and 1 in STREAM only in a cycle where m_valid, m_ready and m_last are all 1; otherwise 0.
REQ-016 Capture: vec_valid && vec_ready SHALL load vec_data, clear the index to 0, and enter or stay in STREAM.
REQ-017 Latency: a capture at edge N SHALL present element 0 with m_valid=1 in the cycle after edge N.
REQ-018 Transfer: m_valid && m_ready SHALL complete one beat, and the index SHALL increment at that edge.
REQ-019 m_data, m_index and m_last SHALL stay stable while m_valid=1 && m_ready=0, and m_valid SHALL NOT drop without a transfer.
REQ-020 m_data SHALL equal capture[m_index]; m_last SHALL be (m_index == DEPTH-1) && m_valid.
REQ-021 Last beat: a last-beat transfer with no simultaneous capture SHALL return the block to IDLE with m_valid=0.
REQ-022 Last beat with a simultaneous capture SHALL stay in STREAM with index 0, giving back-to-back vectors with zero bubble cycles.
REQ-023 vec_valid while vec_ready=0 SHALL drop the vector, leave the capture register unchanged, and set overflow to 1.
REQ-024 overflow SHALL clear only on reset.
REQ-025 Throughput: with m_ready held at 1, one element SHALL transfer per cycle.
REQ-026 The index SHALL wrap from DEPTH-1 to 0 only via REQ-021 or REQ-022.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, index=0, m_valid=0, m_last=0, overflow=0, m_index=0 and m_data=0; vec_ready SHALL be 1 once rst is deasserted.
REQ-028 Reset mid-STREAM SHALL abandon the remaining elements, and no beat SHALL be emitted after reset until a new capture.
REQ-029 The capture register SHALL be cleared to 0 on reset.

Structure
REQ-030 Package sort_pkg SHALL hold the WIDTH/DEPTH default constants and the state enum (IDLE, STREAM).
REQ-031 The block SHALL be a single module with no sub-modules; the index counter and capture register are inline.
REQ-032 vec_valid/vec_data SHALL connect directly to the sorter's valid_out/sorted outputs.

Verification
REQ-033 Basic: capture {1,2,3,5,7,10,18,25} with m_ready=1 -> beats 1,2,3,5,7,10,18,25 in 8 consecutive cycles starting the cycle after capture, m_index 0..7, m_last only on 25, then IDLE.
REQ-034 Backpressure: same vector, m_ready=0 for 3 cycles at index 2 -> m_data=3 and m_index=2 held stable throughout, then sequence resumes without loss or duplication.
REQ-035 Back-to-back: second vector {4,4,6,9,11,12,30,31} strobed on the last-beat cycle of the first -> 16 contiguous beats, no bubble, overflow=0.
REQ-036 Overflow: second vector strobed at index 3 -> overflow=1, first vector's remaining elements 5..25 unchanged, second vector never emitted.
REQ-037 Reset: rst asserted at index 5 -> m_valid=0 and overflow=0 immediately; after release, a new vector streams from element 0.
REQ-038 Duplicates/extremes: vector {0,0,0,0,FFFFFFFF x4} -> exact values emitted in order.
